// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
//   Shared definitions for the LED pattern controller: key event codes,
//   pattern mode codes, the default base-tick period, the internal key-action
//   encoding and small pure helpers used by the controller.
// ---------------------------------------------------------------------------
package led_pattern_pkg;

  // 25 ms base tick at a 50 MHz clock.
  localparam int unsigned TICK_MAX_DEFAULT = 1_250_000;

  // One-hot key events; anything else on key_code means "no event".
  typedef enum logic [3:0] {
    KEY_S1   = 4'b0001,
    KEY_S2   = 4'b0010,
    KEY_S3   = 4'b0100,
    KEY_S4   = 4'b1000,
    KEY_NONE = 4'b1111
  } key_code_e;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // Action requested by the key sampled in the current cycle.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_RUN,    // S1: toggle running
    ACT_MODE,   // S2: next mode
    ACT_SPEED,  // S3: next speed
    ACT_DIR     // S4: toggle direction
  } key_act_e;

  // Only the four exact one-hot codes are events; 1111, 0000 and any
  // multi-hot value fall through to ACT_NONE.
  function automatic key_act_e decode_key(input logic [3:0] code);
    case (code)
      KEY_S1:  return ACT_RUN;
      KEY_S2:  return ACT_MODE;
      KEY_S3:  return ACT_SPEED;
      KEY_S4:  return ACT_DIR;
      default: return ACT_NONE;
    endcase
  endfunction

  // A step happens every (8 >> spd) base ticks; the step counter runs
  // 0..(8 >> spd)-1, so this returns its terminal value (7, 3, 1, 0).
  function automatic logic [2:0] step_ticks_m1(input logic [1:0] spd);
    return 3'((4'd8 >> spd) - 4'd1);
  endfunction

  // Pattern state to active-low LED drive (0 = lit).
  function automatic logic [7:0] pattern_to_led(
    input mode_e       mode,
    input logic [2:0]  pos,
    input logic [3:0]  lvl,
    input logic        dir,
    input logic        blink_on
  );
    logic [7:0] lit;
    lit = '0;
    case (mode)
      MODE_RUN,
      MODE_BOUNCE: lit = 8'd1 << pos;
      // dir=0 fills from LED0 upward, dir=1 fills from LED7 downward.
      MODE_FILL:   lit = dir ? ~(8'hFF >> lvl) : 8'((9'd1 << lvl) - 9'd1);
      MODE_BLINK:  lit = {8{blink_on}};
      default:     lit = '0;
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Base tick generator. A counter runs 0..TICK_MAX-1 while en=1 and holds
//   while en=0; tick is asserted in the cycle the counter sits at
//   TICK_MAX-1 (and en=1), after which it wraps to 0.
//
//   Ports
//     clk   in   system clock, rising edge
//     rst   in   synchronous active-high reset, counter to 0
//     en    in   count enable
//     clr   in   synchronous counter clear (wins over counting)
//     tick  out  one-cycle base tick
// ---------------------------------------------------------------------------
module tick_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned TICK_MAX = TICK_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_MAX - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop in the design samples the values that existed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//   Eight-LED pattern controller driven by four one-cycle key events.
//   Four patterns (RUN, BOUNCE, FILL, BLINK) advance one step every
//   (8 >> spd) base ticks while running. Keys take effect on the edge where
//   they are sampled; a key landing on a step cycle wins and that step is
//   dropped. The LED drive is decoded from the previous cycle's pattern
//   state through a single register.
//
//   Ports
//     clk       in   system clock, rising edge
//     rst       in   synchronous active-high reset
//     key_code  in   4-bit key event (one-hot S1..S4, else no event)
//     led       out  8-bit active-low LED drive, registered
//     mode      out  current pattern mode, registered
//     running   out  1 = pattern advancing, 0 = paused
// ---------------------------------------------------------------------------
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int unsigned TICK_MAX = TICK_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       running
);

  // Pattern and control state.
  logic [7:0] r_led;
  mode_e      r_mode;
  logic       r_running;
  logic [1:0] r_spd;
  logic       r_dir;
  logic [2:0] r_pos;
  logic [3:0] r_lvl;          // FILL level 0..8
  logic       r_blink_on;     // BLINK phase, 0 = all off
  logic       r_bounce_down;  // BOUNCE heading, 0 = towards LED7
  logic [2:0] r_step_cnt;     // base ticks seen in the current step period

  key_act_e   w_act;
  logic       w_tick;
  logic       w_clr_cnt;
  logic       w_step_due;
  logic       w_step;
  logic       w_bounce_head;
  logic [2:0] w_bounce_pos;
  logic       w_bounce_flag;

  assign w_act = decode_key(key_code);

  // Mode and speed changes restart the step period from scratch.
  assign w_clr_cnt = (w_act == ACT_MODE) || (w_act == ACT_SPEED);

  tick_gen #(
    .TICK_MAX (TICK_MAX)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (r_running),
    .clr  (w_clr_cnt),
    .tick (w_tick)
  );

  assign w_step_due = w_tick && (r_step_cnt == step_ticks_m1(r_spd));
  // Any key event in the same cycle takes precedence and drops the step.
  assign w_step     = w_step_due && (w_act == ACT_NONE);

  // BOUNCE next position. At an end the heading is forced inward so the
  // dot never wraps, even if S4 has pointed the flag off the end.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_bounce_head = r_bounce_down;
    if (r_pos == 3'd7) begin
      w_bounce_head = 1'b1;
    end else if (r_pos == 3'd0) begin
      w_bounce_head = 1'b0;
    end
    w_bounce_pos  = w_bounce_head ? (r_pos - 3'd1) : (r_pos + 3'd1);
    // Reaching an end reverses the flag for the following step.
    w_bounce_flag = w_bounce_head;
    if (w_bounce_pos == 3'd7) begin
      w_bounce_flag = 1'b1;
    end else if (w_bounce_pos == 3'd0) begin
      w_bounce_flag = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led         <= 8'hFF;
      r_mode        <= MODE_RUN;
      r_running     <= 1'b0;
      r_spd         <= 2'd0;
      r_dir         <= 1'b0;
      r_pos         <= 3'd0;
      r_lvl         <= 4'd0;
      r_blink_on    <= 1'b0;
      r_bounce_down <= 1'b0;
      r_step_cnt    <= 3'd0;
    end else begin
      // Decode from the state held before this edge: one cycle of latency.
      r_led <= pattern_to_led(r_mode, r_pos, r_lvl, r_dir, r_blink_on);

      case (w_act)
        ACT_RUN: begin
          r_running <= ~r_running;
        end
        ACT_MODE: begin
          r_mode        <= mode_e'(r_mode + 2'd1);
          r_pos         <= 3'd0;
          r_lvl         <= 4'd0;
          r_blink_on    <= 1'b0;
          r_bounce_down <= 1'b0;
        end
        ACT_SPEED: begin
          r_spd <= r_spd + 2'd1;
        end
        ACT_DIR: begin
          r_dir         <= ~r_dir;
          r_bounce_down <= ~r_bounce_down;
        end
        default: begin
        end
      endcase

      // A due step that was dropped by a key still closes its period.
      if (w_clr_cnt) begin
        r_step_cnt <= 3'd0;
      end else if (w_tick) begin
        r_step_cnt <= w_step_due ? 3'd0 : r_step_cnt + 3'd1;
      end

      if (w_step) begin
        case (r_mode)
          MODE_RUN: begin
            r_pos <= r_dir ? (r_pos - 3'd1) : (r_pos + 3'd1);
          end
          MODE_BOUNCE: begin
            r_pos         <= w_bounce_pos;
            r_bounce_down <= w_bounce_flag;
          end
          MODE_FILL: begin
            r_lvl <= (r_lvl == 4'd8) ? 4'd0 : r_lvl + 4'd1;
          end
          MODE_BLINK: begin
            r_blink_on <= ~r_blink_on;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign led     = r_led;
  assign mode    = r_mode;
  assign running = r_running;

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter TICK_MAX, default 1_250_000, giving the base tick period in clk cycles (25 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_code  input  4  key event: 0001=S1, 0010=S2, 0100=S3, 1000=S4, 1111=none; each event is valid for exactly one cycle.
REQ-005 SHALL have port led  output  8  LED drive, active-low (0 = lit), registered.
REQ-006 SHALL have port mode  output  2  current pattern mode, registered.
REQ-007 SHALL have port running  output  1  1 = pattern advancing, 0 = paused.

Function
REQ-008 SHALL treat any key_code value other than the four one-hot codes as "no event", including 1111.
REQ-009 SHALL apply key actions on the clock edge where key_code is sampled, as follows: S1 toggles running; S2 sets mode to (mode+1) mod 4; S3 sets spd to (spd+1) mod 4; S4 toggles dir.
REQ-010 SHALL generate a base tick from a counter 0..TICK_MAX-1, with the tick asserted on TICK_MAX-1 and then wrapping to 0; the counter advances only while running=1.
REQ-011 SHALL advance the pattern by one step after (8 >> spd) base ticks: 8, 4, 2 or 1 ticks for spd = 0..3.
REQ-012 SHALL hold all counters, position and led unchanged while running=0.
REQ-013 SHALL operate mode 0 (RUN) as: one lit LED at pos; each step moves pos +1 (dir=0) or -1 (dir=1), wrapping 7->0 and 0->7.
REQ-014 SHALL operate mode 1 (BOUNCE) as: one lit LED at pos moving per an internal bounce flag; the flag reverses when a step reaches pos 7 or pos 0; S4 also inverts the flag.
REQ-015 SHALL operate mode 2 (FILL) as: lvl 0..8 with lvl lowest LEDs lit (dir=0) or lvl highest LEDs lit (dir=1); each step goes lvl+1, and lvl 8 goes to 0.
REQ-016 SHALL operate mode 3 (BLINK) as: each step toggles all 8 LEDs between off and on; the phase after a mode entry is off.
REQ-017 SHALL, on an S2 event, clear pos, lvl, blink phase, bounce flag, step counter and base counter.
REQ-018 SHALL, on an S3 event, clear the step counter and base counter, and leave pos and lvl unchanged.
REQ-019 SHALL, when a key event coincides with a step, apply the key action and suppress that step.
REQ-020 SHALL have led reflect the pattern state with 1-cycle latency: led is registered from the state of the previous cycle.

Reset
REQ-021 SHALL, when rst=1 at a clock edge, set led=8'hFF, mode=0, running=0, spd=0, dir=0, pos=0, lvl=0, blink phase off, bounce flag up, and all counters to 0.
REQ-022 SHALL set led to 8'hFE (pos 0 lit) on the first edge after rst deasserts.
REQ-023 SHALL give rst priority over a key event and a step occurring in the same cycle.
REQ-024 SHALL return to the full reset state on a mid-pattern reset, with no residual step pending.

Structure
REQ-025 SHALL define the following in shared package led_pattern_pkg: key codes (KEY_S1..KEY_S4, KEY_NONE), mode codes (MODE_RUN, MODE_BOUNCE, MODE_FILL, MODE_BLINK) and the default TICK_MAX.
REQ-026 SHALL implement the base tick counter as sub-module tick_gen (ports clk, rst, en, clr, tick; parameter TICK_MAX), instantiated once.
REQ-027 SHALL implement the pattern-to-led decode as a single registered stage with no additional pipelining.

Verification (TICK_MAX=4 in all benches)
REQ-028 SHALL verify reset then idle: release rst, apply no keys for 100 cycles -> led=FE constant, running=0, mode=0.
REQ-029 SHALL verify RUN at spd 0: pulse S1 -> first step 32 cycles later, led=FD; after 8 steps led=FE (wrap).
REQ-030 SHALL verify S4 in RUN: pulse S4 at pos 0 -> next step led=7F (pos 7).
REQ-031 SHALL verify FILL: pulse S2 twice, then S1, spd 3 -> led sequence FE, FC, ..., 00, FF at 4-cycle step spacing.
REQ-032 SHALL verify the key/step collision: pulse S2 on the exact step cycle -> step suppressed, mode increments, pos=0, next step a full period later.
REQ-033 SHALL verify pause and mid-run reset: pulse S1 while running -> led frozen 200 cycles; assert rst mid-run -> next cycle led=FF, then FE, with mode=0 and running=0.
